// File: rtl/shift_reg_pkg.sv
// Shared mode encoding for the universal shift register.
package shift_reg_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROTL = 3'b100;
    localparam mode_t MODE_ROTR = 3'b101;
    localparam mode_t MODE_RSV6 = 3'b110;
    localparam mode_t MODE_RSV7 = 3'b111;

endpackage

// File: rtl/_dff_r_set_en.sv
// Single storage bit: synchronous reset beats synchronous set beats enable.
module _dff_r_set_en (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic en,
    input  logic d,
    output logic q
);

    // One flop; reset/set/enable all evaluated on the rising edge only.
    always_ff @(posedge clk) begin
        if (reset)
            q <= 1'b0;
        else if (set)
            q <= 1'b1;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/_shift_reg_univ.sv
// Universal shift register: hold / load / shift left / shift right and,
// when SHIFT_ROTATE_EN is defined, rotate left / rotate right.
// Without SHIFT_ROTATE_EN the rotate codes act as hold and no rotate
// paths exist. shift_cnt counts shift/rotate cycles since the last
// load, set or reset and saturates at WIDTH.
module _shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       si_r,
    input  logic                       si_l,
    output logic [WIDTH-1:0]           q,
    output logic                       so_l,
    output logic                       so_r,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       drained
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] nxt;
    logic             en;
    logic             is_shift;

    // Next-value mux; en gates the per-bit flops so hold costs nothing.
    always_comb begin
        nxt      = q;
        en       = 1'b0;
        is_shift = 1'b0;
        case (mode_t'(mode))
            MODE_LOAD: begin
                nxt = d;
                en  = 1'b1;
            end
            MODE_SHL: begin
                nxt      = {q[WIDTH-2:0], si_r};
                en       = 1'b1;
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                nxt      = {si_l, q[WIDTH-1:1]};
                en       = 1'b1;
                is_shift = 1'b1;
            end
`ifdef SHIFT_ROTATE_EN
            MODE_ROTL: begin
                nxt      = {q[WIDTH-2:0], q[WIDTH-1]};
                en       = 1'b1;
                is_shift = 1'b1;
            end
            MODE_ROTR: begin
                nxt      = {q[0], q[WIDTH-1:1]};
                en       = 1'b1;
                is_shift = 1'b1;
            end
`endif
            default: begin
                nxt      = q;
                en       = 1'b0;
                is_shift = 1'b0;
            end
        endcase
    end

    // Per-bit storage array.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        _dff_r_set_en u_bit (
            .clk   (clk),
            .reset (reset),
            .set   (set),
            .en    (en),
            .d     (nxt[i]),
            .q     (q[i])
        );
    end

    // Shift counter: cleared by reset/set/load, saturates at WIDTH.
    always_ff @(posedge clk) begin
        if (reset || set)
            shift_cnt <= '0;
        else if (mode_t'(mode) == MODE_LOAD)
            shift_cnt <= '0;
        else if (is_shift && shift_cnt != CNT_MAX)
            shift_cnt <= shift_cnt + CW'(1);
    end

    assign so_l    = q[WIDTH-1];
    assign so_r    = q[0];
    assign drained = (shift_cnt == CNT_MAX);

endmodule

// File: doc/_shift_reg_univ.md
_SHIFT_REG_UNIV -- requirements
Module: _shift_reg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port set  input  1  synchronous, active-high set; drives all register bits to 1.
REQ-005 SHALL have port mode  input  3  operation select; codes per REQ-013.
REQ-006 SHALL have port d  input  WIDTH  parallel load data.
REQ-007 SHALL have port si_r  input  1  serial in, enters at bit 0 on shift-left.
REQ-008 SHALL have port si_l  input  1  serial in, enters at bit WIDTH-1 on shift-right.
REQ-009 SHALL have port q  output  WIDTH  registered parallel out.
REQ-010 SHALL have ports so_l and so_r  output  1 each  q[WIDTH-1] and q[0], combinational from q.
REQ-011 SHALL have port shift_cnt  output  $clog2(WIDTH+1)  number of shift/rotate operations since last load, set or reset.
REQ-012 SHALL have port drained  output  1  high when shift_cnt == WIDTH, combinational from shift_cnt.

Function
REQ-013 Mode codes SHALL be: 000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 110/111 hold.
REQ-014 Priority per edge SHALL be reset > set > mode.
REQ-015 load: q <= d, shift_cnt <= 0, one-cycle latency.
REQ-016 shl: q <= {q[WIDTH-2:0], si_r}; shr: q <= {si_l, q[WIDTH-1:1]}.
REQ-017 rotl: q <= {q[WIDTH-2:0], q[WIDTH-1]}; rotr: q <= {q[0], q[WIDTH-1:1]}.
REQ-018 Each shl/shr/rotl/rotr cycle SHALL increment shift_cnt by 1, saturating at WIDTH (no wrap).
REQ-019 hold and reserved codes SHALL leave q and shift_cnt unchanged.
REQ-020 set SHALL give q = all ones, shift_cnt = 0, regardless of mode.
REQ-021 Shifting while drained SHALL still update q per mode; shift_cnt stays WIDTH.

Reset
REQ-022 reset SHALL give q = 0, shift_cnt = 0, drained = 0 at the next rising edge, overriding set and mode, including mid-shift sequences.
REQ-023 No asynchronous path SHALL exist from reset or set to any output.

Configuration
REQ-024 Macro SHIFT_ROTATE_EN: defined -> rotl/rotr per REQ-017 and counted per REQ-018.
REQ-025 SHIFT_ROTATE_EN undefined -> codes 100/101 SHALL behave as hold (q and shift_cnt unchanged); no rotate logic synthesised.

Structure
REQ-026 Shared package shift_reg_pkg SHALL hold the 3-bit mode typedef and MODE_* code constants.
REQ-027 Per-bit storage SHALL be sub-module _dff_r_set_en (1-bit flop: sync reset, sync set, enable, d), instantiated WIDTH times via generate; next-value mux and counter live in the top.

Verification (WIDTH=8)
REQ-028 reset=1, set=1, mode=load, d=8'hA5 for one edge -> q=8'h00, shift_cnt=0, drained=0.
REQ-029 load 8'hA5, then shl with si_r=1 x3 -> q=8'h4B, 8'h97, 8'h2F; shift_cnt=3.
REQ-030 load 8'hA5, shr si_l=0 x8 -> q=8'h00, shift_cnt=8, drained=1; 9th shr -> shift_cnt stays 8.
REQ-031 load 8'hA5, rotl x1 -> with SHIFT_ROTATE_EN q=8'h4B, shift_cnt=1; without, q=8'hA5, shift_cnt=0.
REQ-032 set=1 with mode=load, d=8'h00 -> q=8'hFF, shift_cnt=0; after 3 shl, assert reset with mode=shl -> q=8'h00, shift_cnt=0.
